// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the FP32 accumulator and its add_sub datapath.
package fp_acc_pkg;

   localparam int unsigned FP32_W = 32;
   localparam int unsigned EXC_W  = 5;

   localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
   localparam logic [FP32_W-1:0] FP32_QNAN     = 32'h7fc0_0000;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   typedef enum logic {ACCUM, DONE} state_t;

endpackage

// File: rtl/add_sub.sv
// Combinational FP32 adder/subtractor: z = x +/- y with selectable rounding.
// exceptions = {invalid, div_by_zero(always 0), overflow, underflow, inexact}.
module add_sub
   import fp_acc_pkg::*;
(
   input  logic [FP32_W-1:0] in_x,
   input  logic [FP32_W-1:0] in_y,
   input  logic              operation,
   input  logic [2:0]        round_mode,
   output logic [FP32_W-1:0] out_z,
   output logic [EXC_W-1:0]  exceptions
);

   localparam int unsigned SW = 28;

   logic          sx, sy, sa, sb, eff_sub, swap;
   logic [7:0]    ex, ey, ea_raw, eb_raw, ea, eb, d, lim, sh;
   logic [22:0]   fx, fy, fa, fb;
   logic          x_nan, y_nan, x_inf, y_inf, x_snan, y_snan;
   logic [SW-1:0] ma, mb, mb_sh, mb_al, sum;
   logic [4:0]    d_c, lz;
   logic          mb_st;
   logic [26:0]   norm;
   logic [8:0]    e_n, field;
   logic          g, rs, lsb, nx, round_up, ovf, to_inf;
   logic [31:0]   rnd;

   assign sx = in_x[31];
   assign ex = in_x[30:23];
   assign fx = in_x[22:0];
   assign sy = in_y[31] ^ operation;
   assign ey = in_y[30:23];
   assign fy = in_y[22:0];

   assign x_nan  = (ex == 8'hff) && (fx != 23'd0);
   assign y_nan  = (ey == 8'hff) && (fy != 23'd0);
   assign x_inf  = (ex == 8'hff) && (fx == 23'd0);
   assign y_inf  = (ey == 8'hff) && (fy == 23'd0);
   assign x_snan = x_nan && !fx[22];
   assign y_snan = y_nan && !fy[22];

   // Order operands so that |a| >= |b|; the result takes the sign of a.
   assign swap   = {ey, fy} > {ex, fx};
   assign sa     = swap ? sy : sx;
   assign sb     = swap ? sx : sy;
   assign ea_raw = swap ? ey : ex;
   assign eb_raw = swap ? ex : ey;
   assign fa     = swap ? fy : fx;
   assign fb     = swap ? fx : fy;
   assign ea     = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
   assign eb     = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
   assign eff_sub = sa ^ sb;

   assign ma = {1'b0, ea_raw != 8'd0, fa, 3'b000};
   assign mb = {1'b0, eb_raw != 8'd0, fb, 3'b000};

   // Align b with guard/round/sticky retained in the low three bits.
   assign d     = ea - eb;
   assign d_c   = (d > 8'd28) ? 5'd28 : d[4:0];
   assign mb_sh = mb >> d_c;
   assign mb_st = |(mb & ((SW'(1) << d_c) - SW'(1)));
   assign mb_al = mb_sh | {27'd0, mb_st};
   assign sum   = eff_sub ? (ma - mb_al) : (ma + mb_al);

   always_comb begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
   end

   // Normalise, never shifting below the minimum exponent (gradual underflow).
   assign lim = ea - 8'd1;
   assign sh  = (8'(lz) > lim) ? lim : 8'(lz);

   always_comb begin
      if (sum[27]) begin
         norm = {sum[27:2], |sum[1:0]};
         e_n  = 9'(ea) + 9'd1;
      end else begin
         norm = sum[26:0] << sh;
         e_n  = 9'(ea - sh);
      end
   end

   assign field = norm[26] ? e_n : 9'd0;
   assign g     = norm[2];
   assign rs    = |norm[1:0];
   assign lsb   = norm[3];
   assign nx    = |norm[2:0];

   always_comb begin
      case (round_mode)
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = sa & nx;
         RM_RUP:  round_up = !sa & nx;
         RM_RMM:  round_up = g;
         default: round_up = g & (rs | lsb);
      endcase
   end

   // Mantissa carry ripples into the exponent field, covering subnormal->normal too.
   assign rnd    = {field, norm[25:3]} + {31'd0, round_up};
   assign ovf    = rnd[31:23] >= 9'd255;
   assign to_inf = (round_mode == RM_RTZ) ? 1'b0 :
                   (round_mode == RM_RDN) ? sa :
                   (round_mode == RM_RUP) ? !sa : 1'b1;

   always_comb begin
      out_z      = {sa, rnd[30:0]};
      exceptions = {1'b0, 1'b0, 1'b0, (field == 9'd0) && nx, nx};
      if (x_nan || y_nan) begin
         out_z      = FP32_QNAN;
         exceptions = {x_snan || y_snan, 4'b0000};
      end else if (x_inf && y_inf && (sx != sy)) begin
         out_z      = FP32_QNAN;
         exceptions = 5'b10000;
      end else if (x_inf || y_inf) begin
         out_z      = {x_inf ? sx : sy, 8'hff, 23'd0};
         exceptions = '0;
      end else if (sum == '0) begin
         out_z      = {eff_sub ? (round_mode == RM_RDN) : sa, 31'd0};
         exceptions = '0;
      end else if (ovf) begin
         out_z      = to_inf ? {sa, 8'hff, 23'd0} : {sa, 8'hfe, 23'h7fffff};
         exceptions = 5'b00101;
      end
   end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming FP32 reduction: folds each accepted beat into a running sum and
// presents sum, sticky exceptions and beat count once the last beat is taken.
module fp_accumulator
   import fp_acc_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP32_W-1:0] in_data,
   input  logic              in_sub,
   input  logic              in_last,
   input  logic [2:0]        round_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP32_W-1:0] out_sum,
   output logic [EXC_W-1:0]  out_exc,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_cnt_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   logic [FP32_W-1:0]   acc, add_z;
   logic [EXC_W-1:0]    exc, add_exc;
   logic [CNT_W-1:0]    count;
   logic                sat;
   logic                accept;

   add_sub u_add_sub (
      .in_x       (acc),
      .in_y       (in_data),
      .operation  (in_sub),
      .round_mode (round_mode),
      .out_z      (add_z),
      .exceptions (add_exc)
   );

   // in_ready depends only on state, clear and rst -- never on out_ready.
   assign in_ready    = (state == ACCUM) && !clear && !rst;
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state == DONE);
   assign out_sum     = acc;
   assign out_exc     = exc;
   assign out_count   = count;
   assign out_cnt_sat = sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
         acc   <= FP32_POS_ZERO;
         exc   <= '0;
         count <= '0;
         sat   <= 1'b0;
      end else if (clear) begin
         state <= ACCUM;
         acc   <= FP32_POS_ZERO;
         exc   <= '0;
         count <= '0;
         sat   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= add_z;
                  exc <= exc | add_exc;
                  if (count == CNT_MAX) sat <= 1'b1;
                  else                  count <= count + CNT_W'(1);
                  if (in_last) state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= FP32_POS_ZERO;
                  exc   <= '0;
                  count <= '0;
                  sat   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: vector table plus hand-written handshake,
// reset, clear and saturation sequences.
module tb_fp_accumulator;

   localparam int unsigned CW = 3;
   localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RUP = 3'b011;

   logic          clk, rst, clear, in_valid, in_ready, in_sub, in_last;
   logic [31:0]   in_data, out_sum;
   logic [2:0]    round_mode;
   logic          out_valid, out_ready, out_cnt_sat;
   logic [4:0]    out_exc;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_fail   = 0;

   fp_accumulator #(.CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sub      (in_sub),
      .in_last     (in_last),
      .round_mode  (round_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_exc     (out_exc),
      .out_count   (out_count),
      .out_cnt_sat (out_cnt_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      int              n;
      logic [2:0][31:0] d;
      logic [2:0]      sub;
      logic [2:0]      rm;
      logic [31:0]     e_sum;
      logic [4:0]      e_exc;
      int              e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic void add_vec(string name, int n, logic [31:0] d0, logic [31:0] d1,
                                   logic [31:0] d2, logic [2:0] sub, logic [2:0] rm,
                                   logic [31:0] es, logic [4:0] ee, int ec);
      vec_t v;
      v.name = name; v.n = n;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      v.sub = sub; v.rm = rm; v.e_sum = es; v.e_exc = ee; v.e_cnt = ec;
      vq.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic beat(logic [31:0] d, logic sub, logic last, logic [2:0] rm);
      in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last; round_mode = rm;
      #1;
      check("beat_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Checks the result right after the last beat, then completes the handshake.
   task automatic expect_result(string name, logic [31:0] es, logic [4:0] ee, int ec, logic esat);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_sum"},   out_sum, es);
      check({name, "_exc"},   32'(out_exc), 32'(ee));
      check({name, "_count"}, 32'(out_count), 32'(ec));
      check({name, "_sat"},   32'(out_cnt_sat), 32'(esat));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_released"}, 32'(out_valid), 32'd0);
      check({name, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0;
      in_last = 1'b0; round_mode = RNE; out_ready = 1'b0;

      add_vec("three_ones",  3, 32'h3f800000, 32'h3f800000, 32'h3f800000, 3'b000, RNE, 32'h40400000, 5'b00000, 3);
      add_vec("two_minus_1", 2, 32'h40000000, 32'h3f800000, 32'h0,        3'b010, RNE, 32'h3f800000, 5'b00000, 2);
      add_vec("ovf_rne",     2, 32'h7f7fffff, 32'h7f7fffff, 32'h0,        3'b000, RNE, 32'h7f800000, 5'b00101, 2);
      add_vec("ovf_rtz",     2, 32'h7f7fffff, 32'h7f7fffff, 32'h0,        3'b000, RTZ, 32'h7f7fffff, 5'b00101, 2);
      add_vec("ovf_sticky",  3, 32'h7f7fffff, 32'h7f7fffff, 32'h3f800000, 3'b000, RNE, 32'h7f800000, 5'b00101, 3);
      add_vec("neg_one",     1, 32'hbf800000, 32'h0,        32'h0,        3'b000, RNE, 32'hbf800000, 5'b00000, 1);
      add_vec("neg_zero",    1, 32'h80000000, 32'h0,        32'h0,        3'b000, RNE, 32'h00000000, 5'b00000, 1);
      add_vec("sub_first",   1, 32'h3f800000, 32'h0,        32'h0,        3'b001, RNE, 32'hbf800000, 5'b00000, 1);
      add_vec("tie_even",    2, 32'h3f800000, 32'h33800000, 32'h0,        3'b000, RNE, 32'h3f800000, 5'b00001, 2);
      add_vec("tie_rup",     2, 32'h3f800000, 32'h33800000, 32'h0,        3'b000, RUP, 32'h3f800001, 5'b00001, 2);
      add_vec("cancel",      2, 32'h3f800000, 32'h3f800000, 32'h0,        3'b010, RNE, 32'h00000000, 5'b00000, 2);
      add_vec("inf_m_inf",   2, 32'h7f800000, 32'h7f800000, 32'h0,        3'b010, RNE, 32'h7fc00000, 5'b10000, 2);
      add_vec("nan_prop",    2, 32'h7fc00000, 32'h3f800000, 32'h0,        3'b000, RNE, 32'h7fc00000, 5'b00000, 2);

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   out_sum,        32'd0);
      check("rst_out_exc",   32'(out_exc),   32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);

      foreach (vq[k]) begin
         for (int i = 0; i < vq[k].n; i++) begin
            beat(vq[k].d[i], vq[k].sub[i], i == vq[k].n - 1, vq[k].rm);
            if (i < vq[k].n - 1) check({vq[k].name, "_early_valid"}, 32'(out_valid), 32'd0);
         end
         expect_result(vq[k].name, vq[k].e_sum, vq[k].e_exc, vq[k].e_cnt, 1'b0);
      end

      // Backpressure: result held while out_ready stays low.
      beat(32'h3f800000, 1'b0, 1'b1, RNE);
      in_valid = 1'b1; in_data = 32'h40000000; in_sub = 1'b0; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_valid",    32'(out_valid), 32'd1);
         check("hold_sum",      out_sum, 32'h3f800000);
         check("hold_count",    32'(out_count), 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bubble_valid", 32'(out_valid), 32'd0);
      check("bubble_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      expect_result("held_beat", 32'h40000000, 5'b00000, 1, 1'b0);

      // Reset mid-vector discards the partial sum.
      beat(32'h3f800000, 1'b0, 1'b0, RNE);
      beat(32'h3f800000, 1'b0, 1'b0, RNE);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_valid",    32'(out_valid), 32'd0);
      check("midrst_sum",      out_sum, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      beat(32'h40400000, 1'b0, 1'b1, RNE);
      expect_result("after_rst", 32'h40400000, 5'b00000, 1, 1'b0);

      // Clear mid-vector: the clear-cycle beat is refused.
      beat(32'h3f800000, 1'b0, 1'b0, RNE);
      beat(32'h3f800000, 1'b0, 1'b0, RNE);
      clear = 1'b1; in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b0;
      #1;
      check("clear_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      check("clear_count", 32'(out_count), 32'd0);
      beat(32'hbf800000, 1'b0, 1'b1, RNE);
      expect_result("after_clear", 32'hbf800000, 5'b00000, 1, 1'b0);

      // Clear while a result is pending drops it.
      beat(32'h3f800000, 1'b0, 1'b1, RNE);
      check("pend_valid", 32'(out_valid), 32'd1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("drop_valid", 32'(out_valid), 32'd0);
      check("drop_sum",   out_sum, 32'd0);

      // Counter saturation: nine beats into a 3-bit counter.
      for (int i = 0; i < 9; i++) beat(32'h3f800000, 1'b0, i == 8, RNE);
      expect_result("saturate", 32'h41100000, 5'b00000, 7, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
